fabric_result_queue: RTL and testbench

FABRIC_RESULT_QUEUE -- requirements
Module: fabric_result_queue

---
 rtl/fabric_result_queue_if.sv | 39 +++
 rtl/fabric_result_queue.sv | 112 +++++++++++
 tb/tb_fabric_result_queue.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fabric_result_queue_if.sv
// Bundled request, fabric, kill and result signals of fabric_result_queue.
// The slave modport is the queue's view; master is the driving side.
interface fabric_result_queue_if;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [3:0]  req_id_i;
   logic [4:0]  req_rd_i;
   logic [31:0] req_rs1_i;
   logic [31:0] req_rs2_i;
   logic [6:0]  req_latency_i;
   logic [31:0] fabric_rs1_o;
   logic [31:0] fabric_rs2_o;
   logic        fabric_start_o;
   logic [31:0] fabric_result_i;
   logic        fabric_done_i;
   logic        kill_valid_i;
   logic [3:0]  kill_id_i;
   logic        res_valid_o;
   logic        res_ready_i;
   logic [3:0]  res_id_o;
   logic [4:0]  res_rd_o;
   logic [31:0] res_data_o;
   logic        res_err_o;
   logic        busy_o;

   modport slave (
      input  req_valid_i, req_id_i, req_rd_i, req_rs1_i, req_rs2_i, req_latency_i,
      input  fabric_result_i, fabric_done_i, kill_valid_i, kill_id_i, res_ready_i,
      output req_ready_o, fabric_rs1_o, fabric_rs2_o, fabric_start_o,
      output res_valid_o, res_id_o, res_rd_o, res_data_o, res_err_o, busy_o
   );

   modport master (
      output req_valid_i, req_id_i, req_rd_i, req_rs1_i, req_rs2_i, req_latency_i,
      output fabric_result_i, fabric_done_i, kill_valid_i, kill_id_i, res_ready_i,
      input  req_ready_o, fabric_rs1_o, fabric_rs2_o, fabric_start_o,
      input  res_valid_o, res_id_o, res_rd_o, res_data_o, res_err_o, busy_o
   );
endinterface

// File: rtl/fabric_result_queue.sv
// Launches one fabric operation at a time and queues its tagged result in a
// register-based first-word-fall-through FIFO.
module fabric_result_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter bit          USE_DONE = 1'b1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   fabric_result_queue_if.slave bus
);
   localparam int unsigned   AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned   CW   = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic {IDLE, RUN} state_t;

   typedef struct packed {
      logic [3:0]  id;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        err;
   } entry_t;

   state_t        state;
   logic [6:0]    counter;
   logic          timeout_en;
   logic [3:0]    cur_id;
   logic [4:0]    cur_rd;
   entry_t        mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          accept;
   logic          pop;
   logic          kill_hit;
   logic          push;
   entry_t        push_entry;

   assign bus.req_ready_o = (state == IDLE) && (count < FULL);
   assign bus.busy_o      = (state == RUN);
   assign bus.res_valid_o = (count != '0);
   assign {bus.res_id_o, bus.res_rd_o, bus.res_data_o, bus.res_err_o} = mem[rd_ptr];

   // A matching kill suppresses any completion in the same cycle.
   always_comb begin
      accept     = bus.req_valid_i && bus.req_ready_o;
      pop        = bus.res_valid_o && bus.res_ready_i;
      kill_hit   = (state == RUN) && bus.kill_valid_i && (bus.kill_id_i == cur_id);
      push       = 1'b0;
      push_entry = '{id: cur_id, rd: cur_rd, data: bus.fabric_result_i, err: 1'b0};
      if ((state == RUN) && !kill_hit) begin
         if (USE_DONE) begin
            if (bus.fabric_done_i) begin
               push = 1'b1;
            end else if (timeout_en && (counter == '0)) begin
               push           = 1'b1;
               push_entry.err = 1'b1;
            end
         end else if (counter == '0) begin
            push = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state              <= IDLE;
         counter            <= '0;
         timeout_en         <= 1'b0;
         cur_id             <= '0;
         cur_rd             <= '0;
         bus.fabric_start_o <= 1'b0;
         bus.fabric_rs1_o   <= '0;
         bus.fabric_rs2_o   <= '0;
         wr_ptr             <= '0;
         rd_ptr             <= '0;
         count              <= '0;
      end else begin
         bus.fabric_start_o <= accept;
         case (state)
            IDLE: begin
               if (accept) begin
                  cur_id           <= bus.req_id_i;
                  cur_rd           <= bus.req_rd_i;
                  bus.fabric_rs1_o <= bus.req_rs1_i;
                  bus.fabric_rs2_o <= bus.req_rs2_i;
                  counter          <= bus.req_latency_i;
                  timeout_en       <= (bus.req_latency_i != '0);
                  state            <= RUN;
               end
            end
            RUN: begin
               if (counter != '0) counter <= counter - 1'b1;
               if (kill_hit || push) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
         assert (!(push && (count == FULL))) else $error("push into full result FIFO");
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= push_entry;
   end
endmodule

// File: tb/tb_fabric_result_queue.sv
// Bench for fabric_result_queue: both completion modes driven with identical
// stimulus and compared every cycle against a queue-based transaction model.
module tb_fabric_result_queue;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        req_valid;
   logic [3:0]  req_id;
   logic [4:0]  req_rd;
   logic [31:0] req_rs1, req_rs2;
   logic [6:0]  req_lat;
   logic [31:0] f_result;
   logic        f_done;
   logic        kill_valid;
   logic [3:0]  kill_id;
   logic        res_ready;

   fabric_result_queue_if b0();
   fabric_result_queue_if b1();

   assign {b0.req_valid_i, b0.req_id_i, b0.req_rd_i, b0.req_rs1_i, b0.req_rs2_i, b0.req_latency_i}
          = {req_valid, req_id, req_rd, req_rs1, req_rs2, req_lat};
   assign {b0.fabric_result_i, b0.fabric_done_i, b0.kill_valid_i, b0.kill_id_i, b0.res_ready_i}
          = {f_result, f_done, kill_valid, kill_id, res_ready};
   assign {b1.req_valid_i, b1.req_id_i, b1.req_rd_i, b1.req_rs1_i, b1.req_rs2_i, b1.req_latency_i}
          = {req_valid, req_id, req_rd, req_rs1, req_rs2, req_lat};
   assign {b1.fabric_result_i, b1.fabric_done_i, b1.kill_valid_i, b1.kill_id_i, b1.res_ready_i}
          = {f_result, f_done, kill_valid, kill_id, res_ready};

   fabric_result_queue #(.DEPTH(4), .USE_DONE(1'b0)) dut0 (.clk_i(clk), .rst_i(rst), .bus(b0));
   fabric_result_queue #(.DEPTH(4), .USE_DONE(1'b1)) dut1 (.clk_i(clk), .rst_i(rst), .bus(b1));

   typedef struct packed {
      logic [3:0]  id;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        err;
   } res_t;

   // Model: expected result queue plus the single in-flight operation.
   res_t        mq [2][$];
   bit          mbusy  [2];
   int unsigned mn     [2];
   logic [3:0]  mid    [2];
   logic [4:0]  mrd    [2];
   int unsigned mlat   [2];
   logic [31:0] mrs1   [2];
   logic [31:0] mrs2   [2];
   bit          mstart [2];

   int tests = 0;
   int fails = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input int d);
      bit rdy;
      if (rst) begin
         mq[d].delete();
         mbusy[d]  = 0;
         mstart[d] = 0;
         mrs1[d]   = '0;
         mrs2[d]   = '0;
      end else begin
         rdy = !mbusy[d] && (mq[d].size() < 4);
         if (res_ready && mq[d].size() != 0) void'(mq[d].pop_front());
         mstart[d] = 0;
         if (mbusy[d]) begin
            mn[d]++;
            if (kill_valid && kill_id == mid[d]) begin
               mbusy[d] = 0;
            end else if (d == 1 && f_done) begin
               mq[d].push_back('{mid[d], mrd[d], f_result, 1'b0});
               mbusy[d] = 0;
            end else if ((d == 0 || mlat[d] != 0) && mn[d] > mlat[d]) begin
               mq[d].push_back('{mid[d], mrd[d], f_result, (d == 1)});
               mbusy[d] = 0;
            end
         end else if (req_valid && rdy) begin
            mbusy[d]  = 1;
            mn[d]     = 0;
            mid[d]    = req_id;
            mrd[d]    = req_rd;
            mlat[d]   = int'(req_lat);
            mrs1[d]   = req_rs1;
            mrs2[d]   = req_rs2;
            mstart[d] = 1;
         end
      end
   endtask

   task automatic check_dut(input int d, input logic busy, input logic rdy, input logic rv,
                            input logic start, input logic [31:0] rs1, input logic [31:0] rs2,
                            input res_t r);
      chk($sformatf("d%0d.busy", d), 64'(busy), 64'(mbusy[d]));
      chk($sformatf("d%0d.req_ready", d), 64'(rdy), 64'(!mbusy[d] && mq[d].size() < 4));
      chk($sformatf("d%0d.res_valid", d), 64'(rv), 64'(mq[d].size() != 0));
      chk($sformatf("d%0d.fabric_start", d), 64'(start), 64'(mstart[d]));
      chk($sformatf("d%0d.fabric_rs1", d), 64'(rs1), 64'(mrs1[d]));
      chk($sformatf("d%0d.fabric_rs2", d), 64'(rs2), 64'(mrs2[d]));
      if (mq[d].size() != 0) chk($sformatf("d%0d.res_entry", d), 64'(r), 64'(mq[d][0]));
   endtask

   task automatic sample();
      @(negedge clk);
      check_dut(0, b0.busy_o, b0.req_ready_o, b0.res_valid_o, b0.fabric_start_o,
                b0.fabric_rs1_o, b0.fabric_rs2_o,
                {b0.res_id_o, b0.res_rd_o, b0.res_data_o, b0.res_err_o});
      check_dut(1, b1.busy_o, b1.req_ready_o, b1.res_valid_o, b1.fabric_start_o,
                b1.fabric_rs1_o, b1.fabric_rs2_o,
                {b1.res_id_o, b1.res_rd_o, b1.res_data_o, b1.res_err_o});
   endtask

   task automatic step();
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      #1;
   endtask

   task automatic cyc();
      sample();
      step();
   endtask

   task automatic idle_wait();
      int k = 0;
      while ((mbusy[0] || mbusy[1] || mq[0].size() != 0 || mq[1].size() != 0) && k < 100) begin
         cyc();
         k++;
      end
      chk("drain_bound", 64'(k < 100), 64'(1));
   endtask

   task automatic set_req(input logic [3:0] id, input logic [4:0] rd, input logic [31:0] rs1,
                          input logic [31:0] rs2, input logic [6:0] lat);
      req_valid = 1'b1;
      req_id    = id;
      req_rd    = rd;
      req_rs1   = rs1;
      req_rs2   = rs2;
      req_lat   = lat;
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_id = '0; req_rd = '0; req_rs1 = '0; req_rs2 = '0;
      req_lat = '0; f_result = '0; f_done = 1'b0; kill_valid = 1'b0; kill_id = '0;
      res_ready = 1'b1;
      step();
      step();
      rst = 1'b0;

      // Reset state
      sample();
      chk("rst.res_valid", 64'(b0.res_valid_o), 64'(0));
      chk("rst.busy", 64'(b1.busy_o), 64'(0));
      chk("rst.req_ready", 64'(b1.req_ready_o), 64'(1));
      step();

      // Fixed latency 3: result at T+5
      f_result = 32'hCAFE;
      set_req(4'd5, 5'd10, 32'h11, 32'h22, 7'd3);
      cyc();
      req_valid = 1'b0;
      sample();
      chk("lat3.start_t1", 64'(b0.fabric_start_o), 64'(1));
      step();
      cyc();
      cyc();
      sample();
      chk("lat3.early_valid", 64'(b0.res_valid_o), 64'(0));
      step();
      sample();
      chk("lat3.valid_t5", 64'(b0.res_valid_o), 64'(1));
      chk("lat3.entry", 64'({b0.res_id_o, b0.res_rd_o, b0.res_data_o, b0.res_err_o}),
          64'({4'd5, 5'd10, 32'hCAFE, 1'b0}));
      chk("lat3.d1_timeout_err", 64'(b1.res_err_o), 64'(1));
      step();
      idle_wait();

      // Done before timeout
      f_result = 32'h1234;
      set_req(4'd3, 5'd1, 32'h5, 32'h6, 7'd8);
      cyc();
      req_valid = 1'b0;
      cyc();
      cyc();
      f_done = 1'b1;
      cyc();
      f_done = 1'b0;
      sample();
      chk("done.valid_t4", 64'(b1.res_valid_o), 64'(1));
      chk("done.data", 64'(b1.res_data_o), 64'(32'h1234));
      chk("done.err", 64'(b1.res_err_o), 64'(0));
      step();
      idle_wait();

      // Timeout with latency 2
      set_req(4'd4, 5'd2, 32'h7, 32'h8, 7'd2);
      cyc();
      req_valid = 1'b0;
      repeat (3) cyc();
      sample();
      chk("tmo.valid_t4", 64'(b1.res_valid_o), 64'(1));
      chk("tmo.err", 64'(b1.res_err_o), 64'(1));
      step();
      idle_wait();

      // Done coinciding with counter reaching zero
      set_req(4'd2, 5'd4, 32'h9, 32'hA, 7'd4);
      cyc();
      req_valid = 1'b0;
      repeat (4) cyc();
      f_done = 1'b1;
      cyc();
      f_done = 1'b0;
      sample();
      chk("tie.valid", 64'(b1.res_valid_o), 64'(1));
      chk("tie.err", 64'(b1.res_err_o), 64'(0));
      step();
      idle_wait();

      // Matching kill beats same-cycle completion
      set_req(4'd9, 5'd4, 32'hB, 32'hC, 7'd4);
      cyc();
      req_valid = 1'b0;
      repeat (4) cyc();
      f_done = 1'b1; kill_valid = 1'b1; kill_id = 4'd9;
      cyc();
      f_done = 1'b0; kill_valid = 1'b0;
      sample();
      chk("kill.d1_ready", 64'(b1.req_ready_o), 64'(1));
      chk("kill.d1_valid", 64'(b1.res_valid_o), 64'(0));
      chk("kill.d0_valid", 64'(b0.res_valid_o), 64'(0));
      step();
      idle_wait();

      // Fill the FIFO with ids 1..4 while the result side stalls
      res_ready = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         f_result = 32'h100 + 32'(k);
         set_req(4'(k), 5'(k), 32'(k), 32'(k), 7'd1);
         cyc();
         req_valid = 1'b0;
         cyc();
         cyc();
      end
      sample();
      chk("full.ready", 64'(b0.req_ready_o), 64'(0));
      chk("full.head", 64'(b0.res_id_o), 64'(1));
      step();
      res_ready = 1'b1;
      cyc();
      sample();
      chk("full.ready_after_pop", 64'(b0.req_ready_o), 64'(1));
      chk("full.next_head", 64'(b1.res_id_o), 64'(2));
      step();
      idle_wait();

      // Reset with an operation in flight and two queued results
      res_ready = 1'b0;
      for (int k = 1; k <= 2; k++) begin
         set_req(4'(k), 5'd7, 32'h1, 32'h2, 7'd1);
         cyc();
         req_valid = 1'b0;
         cyc();
         cyc();
      end
      set_req(4'd6, 5'd8, 32'h3, 32'h4, 7'd10);
      cyc();
      req_valid = 1'b0;
      cyc();
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      sample();
      chk("rrun.valid", 64'(b0.res_valid_o), 64'(0));
      chk("rrun.busy", 64'(b1.busy_o), 64'(0));
      chk("rrun.ready", 64'(b1.req_ready_o), 64'(1));
      chk("rrun.rs1_cleared", 64'(b0.fabric_rs1_o), 64'(0));
      step();
      res_ready = 1'b1;
      repeat (15) cyc();

      // Kill with mismatching id is ignored
      f_result = 32'hBEEF;
      kill_valid = 1'b1; kill_id = 4'd8;
      set_req(4'd7, 5'd3, 32'h33, 32'h44, 7'd3);
      cyc();
      req_valid = 1'b0;
      repeat (4) cyc();
      sample();
      chk("kmis.valid", 64'(b0.res_valid_o), 64'(1));
      chk("kmis.id", 64'(b0.res_id_o), 64'(7));
      step();
      kill_valid = 1'b0;
      idle_wait();

      // Randomized traffic
      for (int i = 0; i < 800; i++) begin
         rst        = ($urandom_range(0, 149) == 0);
         req_valid  = ($urandom_range(0, 1) == 1);
         req_id     = 4'($urandom_range(0, 15));
         req_rd     = 5'($urandom_range(0, 31));
         req_rs1    = $urandom;
         req_rs2    = $urandom;
         req_lat    = 7'($urandom_range(0, 9));
         f_result   = $urandom;
         f_done     = ($urandom_range(0, 6) == 0);
         kill_valid = ($urandom_range(0, 9) == 0);
         kill_id    = ($urandom_range(0, 1) == 1) ? mid[$urandom_range(0, 1)] : 4'($urandom_range(0, 15));
         res_ready  = ($urandom_range(0, 9) < 7);
         cyc();
      end
      rst = 1'b0; req_valid = 1'b0; kill_valid = 1'b0; res_ready = 1'b1;
      f_done = 1'b1;
      cyc();
      f_done = 1'b0;
      idle_wait();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
